// File: rtl/step_pkg.sv
// Shared types and defaults for the step input conditioner.
// Counter widths are derived here so filter and repeat logic agree.
package step_pkg;

    // Step FSM: waiting for a press, or press already acknowledged.
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } step_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int REPEAT_CYCLES_DEF   = 25000000;

    // Bits needed to hold 0 .. max(a,b)-1, never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronizer chain plus stable-count debounce for one raw input.
// A change is accepted only after DEBOUNCE_CYCLES matching samples.
module debounce_filter
    import step_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive disagreeing samples; flip level at terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (synced == level) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_conditioner.sv
// Conditions the w switch and step button for the sequence detector.
// Option macro STEP_AUTOREPEAT_EN adds auto-repeat while step is held.
module step_conditioner
    import step_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic w_raw,
    input  logic step_raw,
    output logic w,
    output logic step
);

    logic        pb;
    step_state_t state;

    // Out-of-range settings leave an empty marker block in the hierarchy.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2)
    begin : g_bad_params
    end

    debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_w_filter (
        .clk  (clk),
        .reset(reset),
        .din  (w_raw),
        .level(w)
    );

    debounce_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb_filter (
        .clk  (clk),
        .reset(reset),
        .din  (step_raw),
        .level(pb)
    );

`ifdef STEP_AUTOREPEAT_EN
    localparam int RW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [RW-1:0] RTERM = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt;

    // Edge-detect the press; re-pulse every REPEAT_CYCLES while held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= 1'b0;
            rcnt  <= '0;
        end else begin
            step <= 1'b0;
            unique case (state)
                IDLE: begin
                    rcnt <= '0;
                    if (pb) begin
                        state <= HELD;
                        step  <= 1'b1;
                    end
                end
                HELD: begin
                    if (!pb) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == RTERM) begin
                        step <= 1'b1;
                        rcnt <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
            endcase
        end
    end
`else
    // Edge-detect the press: one pulse, then wait for release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pb) begin
                        state <= HELD;
                        step  <= 1'b1;
                    end
                end
                HELD: begin
                    if (!pb) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_step_conditioner.sv
// Scoreboard bench for step_conditioner (SYNC=2, DEBOUNCE=4, REPEAT=8).
// Expected w edges and step pulses are queued as absolute edge numbers.
module tb_step_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int REP   = 8;
    localparam int LAT_W = SYNC + DEB;
    localparam int LAT_S = SYNC + DEB + 1;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic w_raw    = 1'b0;
    logic step_raw = 1'b0;
    logic w;
    logic step;

    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   step_q[$];
    int   wedge_q[$];
    logic wval_q[$];
    logic w_prev = 1'b0;

    step_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .w_raw   (w_raw),
        .step_raw(step_raw),
        .w       (w),
        .step    (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                      name, act, exp, cyc);
    endtask

    // Press raised before edge c0+1, released before edge c1+1.
    task automatic push_press(input int c0, input int c1);
        step_q.push_back(c0 + LAT_S);
`ifdef STEP_AUTOREPEAT_EN
        for (int k = 1; REP * k < c1 - c0; k++)
            step_q.push_back(c0 + LAT_S + REP * k);
`else
        if (c1 < c0) $display("note: odd press window");
`endif
    endtask

    task automatic push_w(input int edge_no, input logic v);
        wedge_q.push_back(edge_no);
        wval_q.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor: every step pulse and every w change must match the queues.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            if (step_q.size() == 0) check("step_spurious", cyc, -1);
            else check("step_pulse_edge", cyc, step_q.pop_front());
        end
        if (w !== w_prev) begin
            if (wedge_q.size() == 0) begin
                check("w_spurious", cyc, -1);
            end else begin
                check("w_edge", cyc, wedge_q.pop_front());
                check("w_value", int'(w), int'(wval_q.pop_front()));
            end
        end
        w_prev <= w;
    end

    initial begin
        int c;
        int r;

        // 1: reset held with both raw inputs high
        w_raw    = 1'b1;
        step_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_w", int'(w), 0);
            check("reset_step", int'(step), 0);
        end
        c = cyc;
        reset = 1'b1;
        push_w(c + LAT_W, 1'b1);
        push_press(c, c + 12);
        tick(12);
        w_raw    = 1'b0;
        step_raw = 1'b0;
        push_w(cyc + LAT_W, 1'b0);
        tick(20);

        // 2: clean switch rise then fall
        c = cyc;
        w_raw = 1'b1;
        push_w(c + LAT_W, 1'b1);
        tick(12);
        w_raw = 1'b0;
        push_w(cyc + LAT_W, 1'b0);
        tick(12);

        // 3: 3-cycle glitches never pass
        repeat (5) begin
            w_raw = 1'b1;
            tick(3);
            w_raw = 1'b0;
            tick(3);
        end
        tick(10);
        check("glitch_w", int'(w), 0);

        // 4: bouncy press, long hold, release, re-press
        step_raw = 1'b1; tick(1);
        step_raw = 1'b0; tick(1);
        step_raw = 1'b1; tick(1);
        step_raw = 1'b0; tick(1);
        c = cyc;
        step_raw = 1'b1;
        push_press(c, c + 20);
        tick(20);
        step_raw = 1'b0;
        tick(10);
        c = cyc;
        step_raw = 1'b1;
        push_press(c, c + 10);
        tick(10);
        step_raw = 1'b0;
        tick(20);

        // 5: reset at count 2 of a press, then again while held
        step_raw = 1'b1;
        tick(4);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("midcount_rst_step", int'(step), 0);
        end
        r = cyc;
        reset = 1'b1;
        push_press(r, r + 8);
        tick(8);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("held_rst_step", int'(step), 0);
            check("held_rst_w", int'(w), 0);
        end
        r = cyc;
        reset = 1'b1;
        push_press(r, r + 10);
        tick(10);
        step_raw = 1'b0;
        tick(20);

        // 6: 40-cycle hold (repeats only with the option enabled)
        c = cyc;
        step_raw = 1'b1;
        push_press(c, c + 40);
        tick(40);
        step_raw = 1'b0;
        tick(20);

        check("step_queue_left", step_q.size(), 0);
        check("w_queue_left", wedge_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
